// File: rtl/i2c_cfg_sequencer.sv
// I2C configuration sequencer: after reset, walks a LUT_SIZE-entry register table and issues
// one {SLAVE_ADDR, sub_addr, data} write per entry to the I2C byte controller. It generates the
// controller step timing (i2c_clk/i2c_en), runs the GO/END handshake, retries on NACK and
// guards BUSY with a watchdog.
// Optional feature macro: CFG_READBACK_EN (read back and compare each written entry).
module i2c_cfg_sequencer #(
   parameter int unsigned CLK_DIV    = 500,
   parameter logic [7:0]  SLAVE_ADDR = 8'h42,
   parameter int unsigned LUT_SIZE   = 64,
   parameter int unsigned INIT_DELAY = 1000,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic                        iCLK,
   input  logic                        iRST_N,
   input  logic                        cfg_start,
   output logic [$clog2(LUT_SIZE)-1:0] lut_index,
   input  logic [15:0]                 lut_data,
   output logic                        i2c_clk,
   output logic                        i2c_en,
   output logic [23:0]                 i2c_wdata,
   output logic                        i2c_wr,
   output logic                        i2c_go,
   input  logic                        i2c_ack,
   input  logic                        i2c_end,
   input  logic [7:0]                  i2c_rdata,
   output logic                        cfg_done,
   output logic                        cfg_err,
   output logic [$clog2(LUT_SIZE)-1:0] err_index
);
   localparam int unsigned IW = $clog2(LUT_SIZE);
   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam int unsigned DW = $clog2(INIT_DELAY + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam logic [CW-1:0] DivLast  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SclLo    = CW'(CLK_DIV / 4);
   localparam logic [CW-1:0] SclHi    = CW'(3 * CLK_DIV / 4);
   localparam logic [DW-1:0] InitLast = DW'(INIT_DELAY - 1);
   localparam logic [IW-1:0] IdxLast  = IW'(LUT_SIZE - 1);
   localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRY);
   localparam logic [5:0]    WdogLast = 6'd63;

   typedef enum logic [3:0] {
      StPwrWait, StLoad, StBusy, StRelease, StDone, StError, StRdLoad, StRdBusy, StRdRelease
   } state_e;

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_init, w_init_nxt;
   logic [IW-1:0] r_idx, w_idx_nxt, r_err_idx, w_err_idx_nxt;
   logic [RW-1:0] r_retry, w_retry_nxt;
   logic [5:0]    r_wdog, w_wdog_nxt;
   logic [23:0]   r_wdata, w_wdata_nxt;
   logic          r_go, w_go_nxt, r_ack, w_ack_nxt;
   logic          r_done, w_done_nxt, r_err, w_err_nxt, r_start, w_start_nxt;
   logic          w_en, w_idle, w_start_hit, w_adv, w_fail;
`ifdef CFG_READBACK_EN
   logic          r_wr, w_wr_nxt;
`else
   logic          w_unused_rdata;
   assign w_unused_rdata = ^i2c_rdata;
`endif

   assign w_en        = (r_cnt == DivLast);
   assign w_idle      = (r_state == StDone) || (r_state == StError);
   // A start seen on the en cycle itself is acted on immediately rather than lost.
   assign w_start_hit = r_start | (cfg_start & w_idle);

   // Free-running step divider.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)             r_cnt <= '0;
      else if (r_cnt == DivLast) r_cnt <= '0;
      else                     r_cnt <= r_cnt + CW'(1);
   end

   // Sequencer state and datapath registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state   <= StPwrWait;
         r_init    <= '0;
         r_idx     <= '0;
         r_err_idx <= '0;
         r_retry   <= '0;
         r_wdog    <= '0;
         r_wdata   <= '0;
         r_go      <= 1'b0;
         r_ack     <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_start   <= 1'b0;
`ifdef CFG_READBACK_EN
         r_wr      <= 1'b1;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_init    <= w_init_nxt;
         r_idx     <= w_idx_nxt;
         r_err_idx <= w_err_idx_nxt;
         r_retry   <= w_retry_nxt;
         r_wdog    <= w_wdog_nxt;
         r_wdata   <= w_wdata_nxt;
         r_go      <= w_go_nxt;
         r_ack     <= w_ack_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_start   <= w_start_nxt;
`ifdef CFG_READBACK_EN
         r_wr      <= w_wr_nxt;
`endif
      end
   end

   // Next-state logic; everything except the start latch advances only on step boundaries.
   always_comb begin
      w_state_nxt   = r_state;
      w_init_nxt    = r_init;
      w_idx_nxt     = r_idx;
      w_err_idx_nxt = r_err_idx;
      w_retry_nxt   = r_retry;
      w_wdog_nxt    = r_wdog;
      w_wdata_nxt   = r_wdata;
      w_go_nxt      = r_go;
      w_ack_nxt     = r_ack;
      w_done_nxt    = r_done;
      w_err_nxt     = r_err;
      w_start_nxt   = w_en ? 1'b0 : w_start_hit;
      w_adv         = 1'b0;
      w_fail        = 1'b0;
`ifdef CFG_READBACK_EN
      w_wr_nxt      = r_wr;
`endif
      if (w_en) begin
         case (r_state)
            StPwrWait: begin
               if (r_init == InitLast) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = StLoad;
               end else begin
                  w_init_nxt = r_init + DW'(1);
               end
            end
            StLoad: begin
               w_wdata_nxt = {SLAVE_ADDR, lut_data};
               w_go_nxt    = 1'b1;
               w_wdog_nxt  = '0;
               w_state_nxt = StBusy;
`ifdef CFG_READBACK_EN
               w_wr_nxt    = 1'b1;
`endif
            end
            StBusy, StRdBusy: begin
               if (i2c_end) begin
                  w_ack_nxt   = i2c_ack;
`ifdef CFG_READBACK_EN
                  if (r_state == StRdBusy) w_ack_nxt = i2c_ack | (i2c_rdata != lut_data[7:0]);
`endif
                  w_go_nxt    = 1'b0;
                  w_state_nxt = (r_state == StBusy) ? StRelease : StRdRelease;
               end else if (r_wdog == WdogLast) begin
                  // A controller that never ends is handled like a NACK.
                  w_ack_nxt   = 1'b1;
                  w_go_nxt    = 1'b0;
                  w_state_nxt = (r_state == StBusy) ? StRelease : StRdRelease;
               end else begin
                  w_wdog_nxt = r_wdog + 6'd1;
               end
            end
            StRelease: begin
               if (!i2c_end) begin
`ifdef CFG_READBACK_EN
                  if (!r_ack) w_state_nxt = StRdLoad;
`else
                  w_adv = !r_ack;
`endif
                  w_fail = r_ack;
               end
            end
`ifdef CFG_READBACK_EN
            StRdLoad: begin
               w_wdata_nxt = {SLAVE_ADDR, lut_data[15:8], 8'h00};
               w_wr_nxt    = 1'b0;
               w_go_nxt    = 1'b1;
               w_wdog_nxt  = '0;
               w_state_nxt = StRdBusy;
            end
            StRdRelease: begin
               if (!i2c_end) begin
                  w_adv  = !r_ack;
                  w_fail = r_ack;
               end
            end
`endif
            StDone, StError: begin
               w_go_nxt = 1'b0;
               if (w_start_hit) begin
                  w_done_nxt  = 1'b0;
                  w_err_nxt   = 1'b0;
                  w_idx_nxt   = '0;
                  w_retry_nxt = '0;
                  w_state_nxt = StLoad;
               end
            end
            default: w_state_nxt = StPwrWait;
         endcase

         if (w_adv) begin
            w_retry_nxt = '0;
            if (r_idx == IdxLast) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = StDone;
            end else begin
               w_idx_nxt   = r_idx + IW'(1);
               w_state_nxt = StLoad;
            end
         end
         if (w_fail) begin
            if (r_retry < MaxRetry) begin
               w_retry_nxt = r_retry + RW'(1);
               w_state_nxt = StLoad;
            end else begin
               w_err_idx_nxt = r_idx;
               w_err_nxt     = 1'b1;
               w_state_nxt   = StError;
            end
         end
`ifdef CFG_READBACK_EN
         if (w_adv || w_fail) w_wr_nxt = 1'b1;
`endif
      end
   end

   assign lut_index = r_idx;
   assign i2c_en    = w_en;
   assign i2c_clk   = (r_cnt >= SclLo) && (r_cnt < SclHi);
   assign i2c_wdata = r_wdata;
   assign i2c_go    = r_go;
   assign cfg_done  = r_done;
   assign cfg_err   = r_err;
   assign err_index = r_err_idx;
`ifdef CFG_READBACK_EN
   assign i2c_wr    = r_wr;
`else
   assign i2c_wr    = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for i2c_cfg_sequencer: a behavioural byte-controller model answers GO with
// END/ACK, the stimulus process pushes expected transactions and status checks into queues,
// and a monitor process pops and compares them.
module tb_i2c_cfg_sequencer;
   localparam int unsigned CLK_DIV    = 8;
   localparam int unsigned INIT_DELAY = 2;
   localparam int unsigned LUT_SIZE   = 4;
   localparam int unsigned MAX_RETRY  = 3;

   logic        iCLK      = 1'b0;
   logic        iRST_N    = 1'b1;
   logic        cfg_start = 1'b0;
   logic [1:0]  lut_index;
   logic [15:0] lut_data;
   logic        i2c_clk, i2c_en, i2c_wr, i2c_go;
   logic [23:0] i2c_wdata;
   logic        i2c_ack, i2c_end;
   logic [7:0]  i2c_rdata;
   logic        cfg_done, cfg_err;
   logic [1:0]  err_index;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] rom [4] = '{16'h1012, 16'h2134, 16'h3256, 16'h4378};
   assign lut_data = rom[lut_index];

   i2c_cfg_sequencer #(
      .CLK_DIV   (CLK_DIV),
      .SLAVE_ADDR(8'h42),
      .LUT_SIZE  (LUT_SIZE),
      .INIT_DELAY(INIT_DELAY),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .cfg_start(cfg_start),
      .lut_index(lut_index),
      .lut_data (lut_data),
      .i2c_clk  (i2c_clk),
      .i2c_en   (i2c_en),
      .i2c_wdata(i2c_wdata),
      .i2c_wr   (i2c_wr),
      .i2c_go   (i2c_go),
      .i2c_ack  (i2c_ack),
      .i2c_end  (i2c_end),
      .i2c_rdata(i2c_rdata),
      .cfg_done (cfg_done),
      .cfg_err  (cfg_err),
      .err_index(err_index)
   );

   always #5 iCLK = ~iCLK;

   // Controller model: accepts GO on a step, ends three steps later, clears END once GO drops.
   int   nack_want [4];
   int   nack_seen [4];
   bit   nack_all  [4];
   bit   rd_bad    [4];
   logic m_busy;
   logic [1:0] m_cnt;
   int   m_e;

   function automatic int entry_of(input logic [7:0] sub);
      for (int i = 0; i < 4; i++) if (rom[i][15:8] == sub) return i;
      return 0;
   endfunction

   always_comb m_e = entry_of(i2c_wdata[15:8]);

   always @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         m_busy <= 1'b0; m_cnt <= 2'd0; i2c_end <= 1'b0; i2c_ack <= 1'b0; i2c_rdata <= 8'h00;
      end else if (i2c_en) begin
         if (i2c_end) begin
            if (!i2c_go) i2c_end <= 1'b0;
         end else if (m_busy) begin
            if (m_cnt == 2'd2) begin
               m_busy  <= 1'b0;
               i2c_end <= 1'b1;
               if (!i2c_wr) begin
                  i2c_ack   <= 1'b0;
                  i2c_rdata <= rd_bad[m_e] ? 8'hFF : rom[m_e][7:0];
               end else if (nack_all[m_e]) begin
                  i2c_ack <= 1'b1;
               end else if (nack_seen[m_e] < nack_want[m_e]) begin
                  i2c_ack         <= 1'b1;
                  nack_seen[m_e] <= nack_seen[m_e] + 1;
               end else begin
                  i2c_ack <= 1'b0;
               end
            end else begin
               m_cnt <= m_cnt + 2'd1;
            end
         end else if (i2c_go) begin
            m_busy <= 1'b1;
            m_cnt  <= 2'd0;
         end
      end
   end

   // Scoreboard queues.
   typedef struct packed { logic wr; logic [23:0] wdata; } txn_t;
   typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
   txn_t exp_q [$];
   chk_t chk_q [$];
   logic go_prev = 1'b0;

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = name; c.act = act; c.exp = exp;
      chk_q.push_back(c);
   endtask

   task automatic push_wr(input int e);
      exp_q.push_back({1'b1, 8'h42, rom[e]});
   endtask

   task automatic push_rd(input int e);
      exp_q.push_back({1'b0, 8'h42, rom[e][15:8], 8'h00});
   endtask

   // Monitor: compares queued status checks and every GO rising edge against the scoreboard.
   always @(negedge iCLK) begin
      chk_t c;
      txn_t t;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         n_checks++;
         if (c.act !== c.exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.exp);
         end
      end
      if (i2c_go && !go_prev) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_go: got wr=%0b wdata=%06h, expected no GO", i2c_wr, i2c_wdata);
         end else begin
            t = exp_q.pop_front();
            if ({i2c_wr, i2c_wdata} !== t) begin
               n_errors++;
               $display("FAIL go_txn: got wr=%0b wdata=%06h, expected wr=%0b wdata=%06h",
                        i2c_wr, i2c_wdata, t.wr, t.wdata);
            end
         end
      end
      go_prev <= i2c_go;
   end

   task automatic pulse_start();
      @(negedge iCLK) cfg_start = 1'b1;
      @(negedge iCLK) cfg_start = 1'b0;
   endtask

   // sel 0 waits for cfg_done, sel 1 for cfg_err.
   task automatic wait_flag(input int sel, input int budget, input string name);
      int n = 0;
      while (!((sel == 0) ? cfg_done : cfg_err) && n < budget) begin
         @(posedge iCLK);
         n++;
      end
      #1;
      expect_eq({name, "_reached"}, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_go(input int budget, output int n);
      n = 0;
      while (!i2c_go && n < budget) begin
         @(posedge iCLK);
         n++;
      end
   endtask

   initial begin
      int n;
      #2 iRST_N = 1'b0;
      #1;
      expect_eq("rst_go", 32'(i2c_go), 32'd0);
      expect_eq("rst_wr", 32'(i2c_wr), 32'd1);
      expect_eq("rst_en", 32'(i2c_en), 32'd0);
      expect_eq("rst_clk", 32'(i2c_clk), 32'd0);
      expect_eq("rst_wdata", 32'(i2c_wdata), 32'd0);
      expect_eq("rst_index", 32'(lut_index), 32'd0);
      expect_eq("rst_done", 32'(cfg_done), 32'd0);
      expect_eq("rst_err", 32'(cfg_err), 32'd0);
      expect_eq("rst_err_index", 32'(err_index), 32'd0);
`ifdef CFG_READBACK_EN
      rd_bad[0] = 1'b1;
      for (int a = 0; a < 4; a++) begin push_wr(0); push_rd(0); end
      #20 iRST_N = 1'b1;
      wait_flag(1, 3000, "rb_err");
      repeat (100) @(posedge iCLK);
      #1;
      expect_eq("rb_cfg_err", 32'(cfg_err), 32'd1);
      expect_eq("rb_err_index", 32'(err_index), 32'd0);
      expect_eq("rb_cfg_done", 32'(cfg_done), 32'd0);
      expect_eq("rb_pending", 32'(exp_q.size()), 32'd0);
`else
      // All entries ACKed.
      for (int e = 0; e < 4; e++) push_wr(e);
      #20 iRST_N = 1'b1;
      wait_flag(0, 2000, "t1_done");
      repeat (60) @(posedge iCLK);
      #1;
      expect_eq("t1_done", 32'(cfg_done), 32'd1);
      expect_eq("t1_err", 32'(cfg_err), 32'd0);
      expect_eq("t1_pending", 32'(exp_q.size()), 32'd0);

      // Entry 2 NACKs twice, then ACKs.
      nack_want[2] = nack_seen[2] + 2;
      push_wr(0); push_wr(1); push_wr(2); push_wr(2); push_wr(2); push_wr(3);
      pulse_start();
      repeat (12) @(posedge iCLK);
      #1;
      expect_eq("t2_done_cleared", 32'(cfg_done), 32'd0);
      wait_flag(0, 3000, "t2_done");
      repeat (60) @(posedge iCLK);
      #1;
      expect_eq("t2_done", 32'(cfg_done), 32'd1);
      expect_eq("t2_err", 32'(cfg_err), 32'd0);
      expect_eq("t2_pending", 32'(exp_q.size()), 32'd0);

      // Entry 1 always NACKs: one try plus three retries, then ERROR.
      nack_all[1] = 1'b1;
      push_wr(0); push_wr(1); push_wr(1); push_wr(1); push_wr(1);
      pulse_start();
      wait_flag(1, 3000, "t3_err");
      repeat (200) @(posedge iCLK);
      #1;
      expect_eq("t3_err", 32'(cfg_err), 32'd1);
      expect_eq("t3_err_index", 32'(err_index), 32'd1);
      expect_eq("t3_done", 32'(cfg_done), 32'd0);
      expect_eq("t3_go_low", 32'(i2c_go), 32'd0);
      expect_eq("t3_pending", 32'(exp_q.size()), 32'd0);

      // Restart from ERROR with the slave ACKing: no power-up wait.
      nack_all[1] = 1'b0;
      for (int e = 0; e < 4; e++) push_wr(e);
      pulse_start();
      wait_go(200, n);
      expect_eq("t4_fast_restart", 32'(n <= 20), 32'd1);
      wait_flag(0, 2000, "t4_done");
      repeat (60) @(posedge iCLK);
      #1;
      expect_eq("t4_done", 32'(cfg_done), 32'd1);
      expect_eq("t4_err", 32'(cfg_err), 32'd0);
      expect_eq("t4_pending", 32'(exp_q.size()), 32'd0);

      // Reset during BUSY of entry 1.
      push_wr(0); push_wr(1);
      pulse_start();
      n = 0;
      while (!(i2c_go && i2c_wdata[15:8] == 8'h21) && n < 500) begin
         @(posedge iCLK);
         n++;
      end
      expect_eq("t5_reach_entry1", 32'(n < 500), 32'd1);
      repeat (3) @(posedge iCLK);
      #2 iRST_N = 1'b0;
      #1;
      expect_eq("t5_go_async_drop", 32'(i2c_go), 32'd0);
      expect_eq("t5_done_cleared", 32'(cfg_done), 32'd0);
      repeat (3) @(negedge iCLK);
      expect_eq("t5_pending_before", 32'(exp_q.size()), 32'd0);
      for (int e = 0; e < 4; e++) push_wr(e);
      iRST_N = 1'b1;
      wait_go(200, n);
      expect_eq("t5_init_delay", 32'(n >= 20 && n < 200), 32'd1);
      wait_flag(0, 2000, "t5_done");
      repeat (60) @(posedge iCLK);
      #1;
      expect_eq("t5_done", 32'(cfg_done), 32'd1);
      expect_eq("t5_err", 32'(cfg_err), 32'd0);
      expect_eq("t5_pending", 32'(exp_q.size()), 32'd0);
`endif
      repeat (3) @(posedge iCLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
Upstream command sequencer for the I2C byte controller. After reset it steps through a sensor register table of LUT_SIZE entries and issues one 3-byte write per entry to the controller, {SLAVE_ADDR, sub-address, data}. It generates the controller's I2C_CLK and I2C_EN timing, runs the GO/END handshake, and retries on NACK. It reports completion or failure to the gesture pipeline, which stays gated off until the sensor is configured.

Parameters:
CLK_DIV, 500, iCLK cycles per controller step (one i2c_en pulse per period); must be a multiple of 4, minimum 8
SLAVE_ADDR, 8'h42, 8-bit write address placed in i2c_wdata[23:16]
LUT_SIZE, 64, number of table entries, indices 0..LUT_SIZE-1
INIT_DELAY, 1000, i2c_en periods to wait after reset before the first transaction
MAX_RETRY, 3, retries per entry after a NACK before declaring an error

Ports:
iCLK  in  1  system clock
iRST_N  in  1  async active-low reset
cfg_start  in  1  single-cycle pulse; restarts the sequence from index 0 when in DONE or ERROR
lut_index  out  $clog2(LUT_SIZE)  table address presented to the external register ROM
lut_data  in  16  {sub_addr[15:8], data[7:0]}, combinational from lut_index
i2c_clk  out  1  to controller I2C_CLK
i2c_en  out  1  to controller I2C_EN, 1-cycle pulse per CLK_DIV
i2c_wdata  out  24  to controller I2C_WDATA
i2c_wr  out  1  to controller WR; always 1 except during readback
i2c_go  out  1  to controller GO
i2c_ack  in  1  controller ACK; 1 = NACK seen
i2c_end  in  1  controller END
i2c_rdata  in  8  controller I2C_RDATA (used only by the optional feature)
cfg_done  out  1  sticky; high after all entries succeed
cfg_err  out  1  sticky; high after retries are exhausted
err_index  out  $clog2(LUT_SIZE)  entry index that failed

Behaviour:
- Reset values: all outputs 0, except i2c_wr = 1. Divider count = 0. State = PWR_WAIT.
- Divider: counts 0..CLK_DIV-1 and wraps.
  - i2c_en = 1 when count == CLK_DIV-1.
  - i2c_clk = 1 when count is in [CLK_DIV/4, 3*CLK_DIV/4), so SCL is centred in each step.
  - The divider free-runs in every state.
- Sequencer state changes occur only on cycles where i2c_en = 1, so the sequencer and controller see the same step boundaries.
- PWR_WAIT: counts INIT_DELAY i2c_en pulses, then goes to LOAD with index = 0.
- LOAD: registers i2c_wdata = {SLAVE_ADDR, lut_data}, sets i2c_go = 1, goes to BUSY.
- BUSY: holds i2c_go and i2c_wdata stable. On the first i2c_en where i2c_end = 1, samples i2c_ack, drops i2c_go, goes to RELEASE.
- RELEASE: waits for i2c_end = 0, which the controller clears on its next step with GO low.
  - If the sampled ack = 0: clear the retry count. If index == LUT_SIZE-1, go to DONE; otherwise increment index and go to LOAD.
  - If the sampled ack = 1 and retry < MAX_RETRY: increment retry, go to LOAD with the same index.
  - If the sampled ack = 1 and retries are exhausted: set err_index = index, go to ERROR.
- DONE: cfg_done = 1, i2c_go = 0. ERROR: cfg_err = 1, i2c_go = 0. Both hold until cfg_start or reset.
- cfg_start in DONE or ERROR:
  - Clears cfg_done, cfg_err, index and retry count, then goes to LOAD; PWR_WAIT is skipped.
  - cfg_start in any other state is ignored.
  - cfg_start is latched on any iCLK cycle and acted on at the next i2c_en.
- Lookup timing: lut_index drives the ROM directly; lut_data must be valid one iCLK after lut_index changes. Guaranteed because LOAD samples at the next i2c_en.
- Watchdog: if BUSY lasts 64 i2c_en periods without i2c_end, it is treated as a NACK.
- Reset mid-transaction: i2c_go drops immediately (async), the controller returns to idle, and the sequence restarts from PWR_WAIT.
- Minimum GO-low gap between transactions: 1 i2c_en period, covered by the RELEASE state.

Optional Feature:
CFG_READBACK_EN
- Defined: after each ACKed write the sequencer issues a read of the same sub-address.
  - i2c_wr = 0; i2c_wdata = {SLAVE_ADDR, sub_addr, 8'h00}.
  - A read NACK, or i2c_rdata != data, counts as a failure and goes through the same retry/ERROR path.
  - Adds states RD_LOAD, RD_BUSY, RD_RELEASE.
- Undefined: no readback; i2c_wr is tied to 1 and i2c_rdata is unused.

Test Plan:
- Reset, then CLK_DIV=8, INIT_DELAY=2, LUT_SIZE=4, slave always ACKs -> exactly 4 GO pulses carrying wdata 24'h42_xxxx matching entries 0..3 in order; cfg_done rises after the 4th END; cfg_err = 0.
- Entry 2 NACKs twice, then ACKs (MAX_RETRY=3) -> entry 2 issued 3 times, each with identical wdata; sequence completes; cfg_done = 1.
- Entry 1 always NACKs -> 4 attempts (1 + 3 retries); cfg_err = 1, err_index = 1, cfg_done = 0; no GO afterwards.
- cfg_start pulse in ERROR with the slave now ACKing -> restarts at index 0 with no PWR_WAIT delay; cfg_done = 1, cfg_err = 0.
- iRST_N asserted during BUSY of entry 1 -> i2c_go = 0 in the same cycle; after release, INIT_DELAY is honoured and the sequence restarts at index 0.
- CFG_READBACK_EN defined, slave returns 8'hFF for entry 0 whose data is 8'h12 -> write/read pairs repeat until retries are exhausted; cfg_err = 1, err_index = 0.
